// File: rtl/vu_meter_visualizer_pkg.sv
// Shared encodings for the VU meter: display modes, peak-marker states, level width helper.
package vu_pkg;

    localparam logic VU_MODE_BAR = 1'b0;
    localparam logic VU_MODE_DOT = 1'b1;

    typedef enum logic [1:0] {
        PK_IDLE = 2'd0,
        PK_HOLD = 2'd1,
        PK_FALL = 2'd2
    } pk_state_e;

    // Bits needed to hold a bar level of 0..n inclusive.
    function automatic int vu_lvl_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vu_level_quantizer.sv
// Combinational front end: stereo -> mono magnitude, and registered magnitude -> LED count.
module vu_level_quantizer
    import vu_pkg::*;
#(
    parameter  int NUM_LEDS = 16,
    parameter  int SAMPLE_W = 16,
    localparam int LVL_W    = vu_lvl_w(NUM_LEDS),
    localparam int MAG_W    = SAMPLE_W - 1
) (
    input  logic [2*SAMPLE_W-1:0] audio,
    output logic [MAG_W-1:0]      mag,
    input  logic [MAG_W-1:0]      mag_q,
    output logic [LVL_W-1:0]      inst
);

    localparam int STEP = (1 << (SAMPLE_W - 1)) / NUM_LEDS;

    logic [SAMPLE_W-1:0] l, r;
    logic [SAMPLE_W:0]   sum;
    logic [SAMPLE_W-1:0] avg;
    logic [SAMPLE_W-1:0] neg;
    logic [NUM_LEDS-1:0] above;
    logic                unused_bits;

    assign l   = audio[2*SAMPLE_W-1:SAMPLE_W];
    assign r   = audio[SAMPLE_W-1:0];
    assign sum = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
    // Dropping the LSB of the sign-extended sum is an arithmetic shift (floor).
    assign avg = sum[SAMPLE_W:1];
    assign neg = ~avg + 1'b1;
    assign unused_bits = ^{sum[0], neg[SAMPLE_W-1]};

    always_comb begin
        mag = avg[MAG_W-1:0];
        if (avg[SAMPLE_W-1]) begin
            if (avg == {1'b1, {MAG_W{1'b0}}})
                mag = {MAG_W{1'b1}};
            else
                mag = neg[MAG_W-1:0];
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_th
        localparam logic [MAG_W-1:0] TH = MAG_W'(i * STEP);
        assign above[i] = (mag_q > TH);
    end

    always_comb begin
        inst = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            inst = inst + LVL_W'(above[i]);
    end

endmodule

// File: rtl/vu_meter_visualizer.sv
// Stereo VU meter: 2-stage level pipeline, attack/decay bar, optional peak-hold marker.
// Optional feature macro: VU_PEAK_HOLD_EN builds the peak FSM and marker.
module vu_meter_visualizer
    import vu_pkg::*;
#(
    parameter  int NUM_LEDS      = 16,
    parameter  int SAMPLE_W      = 16,
    parameter  int DECAY_SAMPLES = 480,
    parameter  int HOLD_SAMPLES  = 4800,
    localparam int LVL_W         = vu_lvl_w(NUM_LEDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [2*SAMPLE_W-1:0] input_audio,
    input  logic                  mode,
    output logic [NUM_LEDS-1:0]   leds,
    output logic [LVL_W-1:0]      level
);

    localparam int MAG_W   = SAMPLE_W - 1;
    // One counter width covers both the decay and hold timers.
    localparam int CNT_MAX = (DECAY_SAMPLES > HOLD_SAMPLES) ? DECAY_SAMPLES : HOLD_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [MAG_W-1:0] mag, mag_q;
    logic             s1_vld;
    logic [LVL_W-1:0] inst;
    logic [LVL_W-1:0] bar, bar_nx;
    logic [CNT_W-1:0] decay_cnt, dcnt_nx;

    vu_level_quantizer #(
        .NUM_LEDS (NUM_LEDS),
        .SAMPLE_W (SAMPLE_W)
    ) u_quant (
        .audio (input_audio),
        .mag   (mag),
        .mag_q (mag_q),
        .inst  (inst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_q  <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= sample_valid;
            if (sample_valid)
                mag_q <= mag;
        end
    end

    // Attack is instant; a lower level only pulls the bar down one step per decay period.
    always_comb begin
        bar_nx  = bar;
        dcnt_nx = decay_cnt;
        if (inst >= bar) begin
            bar_nx  = inst;
            dcnt_nx = '0;
        end else if (decay_cnt == CNT_W'(DECAY_SAMPLES - 1)) begin
            bar_nx  = bar - 1'b1;
            dcnt_nx = '0;
        end else begin
            dcnt_nx = decay_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar       <= '0;
            decay_cnt <= '0;
        end else if (s1_vld) begin
            bar       <= bar_nx;
            decay_cnt <= dcnt_nx;
        end
    end

`ifdef VU_PEAK_HOLD_EN
    pk_state_e        pk_state, st_nx;
    logic [LVL_W-1:0] peak, pk_nx;
    logic [CNT_W-1:0] hold_cnt, hcnt_nx;
    logic [CNT_W-1:0] pk_dcnt, pdcnt_nx;

    always_comb begin
        st_nx    = pk_state;
        pk_nx    = peak;
        hcnt_nx  = hold_cnt;
        pdcnt_nx = pk_dcnt;
        if (inst >= peak && inst != '0) begin
            pk_nx   = inst;
            hcnt_nx = '0;
            st_nx   = PK_HOLD;
        end else begin
            case (pk_state)
                PK_HOLD: begin
                    if (hold_cnt == CNT_W'(HOLD_SAMPLES - 1)) begin
                        st_nx    = PK_FALL;
                        pdcnt_nx = '0;
                    end else begin
                        hcnt_nx = hold_cnt + 1'b1;
                    end
                end
                PK_FALL: begin
                    if (pk_dcnt == CNT_W'(DECAY_SAMPLES - 1)) begin
                        pk_nx    = peak - 1'b1;
                        pdcnt_nx = '0;
                    end else begin
                        pdcnt_nx = pk_dcnt + 1'b1;
                    end
                    // Once the marker reaches the bar it rides on it until both hit zero.
                    if (pk_nx <= bar_nx) begin
                        pk_nx = bar_nx;
                        if (bar_nx == '0) begin
                            st_nx    = PK_IDLE;
                            pdcnt_nx = '0;
                        end
                    end
                end
                default: begin
                    st_nx = PK_IDLE;
                    pk_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pk_state <= PK_IDLE;
            peak     <= '0;
            hold_cnt <= '0;
            pk_dcnt  <= '0;
        end else if (s1_vld) begin
            pk_state <= st_nx;
            peak     <= pk_nx;
            hold_cnt <= hcnt_nx;
            pk_dcnt  <= pdcnt_nx;
        end
    end
`endif

    always_comb begin
        leds = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (mode == VU_MODE_DOT)
                leds[i] = (LVL_W'(i + 1) == bar);
            else
                leds[i] = (LVL_W'(i) < bar);
`ifdef VU_PEAK_HOLD_EN
            if (LVL_W'(i + 1) == peak)
                leds[i] = 1'b1;
`endif
        end
    end

    assign level = bar;

endmodule

// File: tb/tb_vu_meter_visualizer.sv
// Self-checking bench for vu_meter_visualizer: table vectors plus ballistics sequences via a scoreboard.
module tb_vu_meter_visualizer;

`ifdef VU_PEAK_HOLD_EN
    localparam bit PK_ON = 1'b1;
`else
    localparam bit PK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] input_audio = '0;
    logic [15:0] leds;
    logic [4:0]  level;

    always #5 clk = ~clk;

    vu_meter_visualizer #(
        .NUM_LEDS      (16),
        .SAMPLE_W      (16),
        .DECAY_SAMPLES (4),
        .HOLD_SAMPLES  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .input_audio  (input_audio),
        .mode         (mode),
        .leds         (leds),
        .level        (level)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        md;
        int          lvl;
        logic [15:0] led;
    } vec_t;

    typedef struct {
        int          lvl;
        logic [15:0] led;
        logic        chk_led;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    vec_t       tv[12];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] vp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Strobes reach the bar two edges after capture; the bench tracks that on its own.
    always @(posedge clk or negedge rst)
        if (!rst) vp <= '0;
        else      vp <= {vp[0], sample_valid};

    always @(negedge clk) begin
        if (rst && vp[1]) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=output required=none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_level"}, 32'(level), 32'(e.lvl));
                if (e.chk_led) chk({e.tag, "_leds"}, 32'(leds), 32'(e.led));
            end
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r, input int lvl,
                        input logic [15:0] led, input logic cl, input string tag);
        exp_t e;
        e.lvl = lvl; e.led = led; e.chk_led = cl; e.tag = tag;
        input_audio  = {l, r};
        sample_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        sb.delete();
        rst = 1'b1;
    endtask

    function automatic logic [15:0] bar_leds(input int b);
        return 16'((32'd1 << b) - 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{16'h3000, 16'h3000, 1'b0, 6,  16'h003F};
        tv[1]  = '{16'hD000, 16'hD000, 1'b0, 6,  16'h003F};
        tv[2]  = '{16'h7FFF, 16'h8000, 1'b0, 1,  16'h0001};
        tv[3]  = '{16'h8000, 16'h8000, 1'b0, 16, 16'hFFFF};
        tv[4]  = '{16'h0000, 16'h0000, 1'b0, 0,  16'h0000};
        tv[5]  = '{16'h0800, 16'h0800, 1'b0, 1,  16'h0001};
        tv[6]  = '{16'h0801, 16'h0801, 1'b0, 2,  16'h0003};
        tv[7]  = '{16'h7FFF, 16'h7FFF, 1'b0, 16, 16'hFFFF};
        tv[8]  = '{16'h3000, 16'h3000, 1'b1, 6,  16'h0020};
        tv[9]  = '{16'h1000, 16'h0000, 1'b0, 1,  16'h0001};
        tv[10] = '{16'h0003, 16'hFFFC, 1'b0, 1,  16'h0001};
        tv[11] = '{16'h8000, 16'h8000, 1'b1, 16, 16'h8000};

        // Strobes while held in reset must leave everything dark.
        repeat (2) @(posedge clk);
        #1;
        input_audio  = 32'h8000_8000;
        sample_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        rst = 1'b1;
        idle(10);
        @(negedge clk);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_leds", 32'(leds), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_reset();
            mode = tv[i].md;
            send(tv[i].l, tv[i].r, tv[i].lvl, tv[i].led, 1'b1, $sformatf("vec%0d", i));
            idle(3);
        end
        mode = 1'b0;

        // Mode is unpipelined: leds follow it within the cycle.
        do_reset();
        send(16'h3000, 16'h3000, 6, 16'h003F, 1'b1, "mode_pre");
        idle(3);
        mode = 1'b1;
        #2;
        chk("mode_dot", 32'(leds), 32'h0020);
        mode = 1'b0;
        #2;
        chk("mode_bar", 32'(leds), 32'h003F);
        idle(1);

        // Decay: one step per 4 zero strobes; idle gaps must not advance the counter.
        do_reset();
        send(16'h3000, 16'h3000, 6, 16'h003F, 1'b1, "dec_att");
        for (int k = 1; k <= 24; k++) begin
            int lv;
            lv = 6 - k / 4;
            send(16'h0, 16'h0, lv, bar_leds(lv), !PK_ON, $sformatf("dec%0d", k));
            if (k % 3 == 0) idle(2);
        end
        idle(5);
        @(negedge clk);
        chk("dec_idle_level", 32'(level), 32'd0);
        @(posedge clk); #1;

        // Attack lands on the sample where the decay counter would expire.
        do_reset();
        send(16'h3000, 16'h3000, 6, 16'h003F, 1'b1, "att_a");
        for (int k = 0; k < 3; k++)
            send(16'h0, 16'h0, 6, 16'h003F, !PK_ON, "att_z");
        send(16'h6000, 16'h6000, 12, 16'h0FFF, 1'b1, "att_hit");
        for (int k = 0; k < 3; k++)
            send(16'h0, 16'h0, 12, 16'h0FFF, 1'b1, "att_hold");
        send(16'h0, 16'h0, 11, PK_ON ? 16'h0FFF : 16'h07FF, 1'b1, "att_dec");
        idle(3);

`ifdef VU_PEAK_HOLD_EN
        // Peak marker: held for 8 strobes, then falls 1 per 4 until it meets the bar.
        do_reset();
        send(16'd20000, 16'd20000, 10, 16'h03FF, 1'b1, "pk_att");
        for (int k = 1; k <= 50; k++) begin
            int          b, p;
            logic [15:0] e;
            b = 10 - k / 4;
            if (b < 0) b = 0;
            p = (k <= 8) ? 10 : 10 - (k - 8) / 4;
            if (p < b) p = b;
            if (p < 0) p = 0;
            e = bar_leds(b);
            if (p > 0) e = e | 16'(32'd1 << (p - 1));
            send(16'h0, 16'h0, b, e, 1'b1, $sformatf("pk%0d", k));
        end
        idle(3);
`endif

        // Reset mid-pipeline discards the in-flight sample.
        do_reset();
        send(16'h3000, 16'h3000, 6, 16'h003F, 1'b1, "mid_pre");
        idle(3);
        input_audio  = 32'h8000_8000;
        sample_valid = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_leds", 32'(leds), 32'd0);
        sb.delete();
        sample_valid = 1'b0;
        #1;
        rst = 1'b1;
        idle(4);
        @(negedge clk);
        chk("mid_flushed", 32'(level), 32'd0);
        @(posedge clk); #1;
        send(16'h3000, 16'h3000, 6, 16'h003F, 1'b1, "mid_post");
        idle(3);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
